// File: rtl/vram_dma.sv
// Block fill / forward-copy engine in front of the 64 KB video RAM.
// It touches the VRAM port only on cycles where mem_grant is high.
module vram_dma #(
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              cfg_we,
    input  logic [2:0]        cfg_addr,
    input  logic [7:0]        cfg_din,
    output logic [7:0]        cfg_dout,
    output logic              busy,
    output logic              done_irq,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_grant
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        CP_RD,
        CP_CAP,
        CP_WR,
        FIN
    } state_t;

    state_t            state;
    state_t            state_nxt;
    state_t            launch_state;
    logic [ADDR_W-1:0] dst;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] len;
    logic [7:0]        value;
    logic [7:0]        hold;
    logic              mode;
    logic              ctrl_wr;
    logic              start_req;
    logic              abort_req;
    logic              last_byte;
    logic [15:0]       dst_rd;
    logic [15:0]       src_rd;
    logic [15:0]       len_rd;

    assign ctrl_wr   = cfg_we && (cfg_addr == 3'd7);
    assign start_req = ctrl_wr && cfg_din[0];
    assign abort_req = ctrl_wr && cfg_din[2];
    assign last_byte = (len == ADDR_W'(1));

    // A zero-length START still produces a completion pulse, but no memory traffic.
    assign launch_state = (len == '0) ? FIN : (cfg_din[1] ? CP_RD : FILL);

    assign dst_rd = 16'(dst);
    assign src_rd = 16'(src);
    assign len_rd = 16'(len);

    // NOTE: state and data registers use non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done_irq  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = dst;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start_req) state_nxt = launch_state;
            end
            FILL: begin
                busy      = 1'b1;
                mem_wdata = value;
                mem_we    = mem_grant;
                if (mem_grant && last_byte) state_nxt = FIN;
            end
            CP_RD: begin
                busy     = 1'b1;
                mem_addr = src;
                if (mem_grant) state_nxt = CP_CAP;
            end
            CP_CAP: begin
                busy      = 1'b1;
                state_nxt = CP_WR;
            end
            CP_WR: begin
                busy      = 1'b1;
                mem_wdata = hold;
                mem_we    = mem_grant;
                if (mem_grant) state_nxt = last_byte ? FIN : CP_RD;
            end
            FIN: begin
                done_irq  = 1'b1;
                state_nxt = start_req ? launch_state : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Abort only applies to a running operation; when idle START has priority.
        if (busy && abort_req) state_nxt = FIN;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            dst   <= '0;
            src   <= '0;
            len   <= '0;
            value <= '0;
            hold  <= '0;
            mode  <= 1'b0;
        end else begin
            if (!busy && cfg_we) begin
                case (cfg_addr)
                    3'd0: dst[7:0]        <= cfg_din;
                    3'd1: dst[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
                    3'd2: src[7:0]        <= cfg_din;
                    3'd3: src[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
                    3'd4: len[7:0]        <= cfg_din;
                    3'd5: len[ADDR_W-1:8] <= cfg_din[ADDR_W-9:0];
                    3'd6: value           <= cfg_din;
                    3'd7: mode            <= cfg_din[1];
                    default: ;
                endcase
            end
            case (state)
                FILL, CP_WR: begin
                    if (mem_grant) begin
                        dst <= dst + 1'b1;
                        len <= len - 1'b1;
                    end
                end
                CP_RD: begin
                    if (mem_grant) src <= src + 1'b1;
                end
                // Synchronous RAM: data for the CP_RD address is on mem_rdata now.
                CP_CAP: hold <= mem_rdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            cfg_dout <= '0;
        end else begin
            case (cfg_addr)
                3'd0: cfg_dout <= dst_rd[7:0];
                3'd1: cfg_dout <= dst_rd[15:8];
                3'd2: cfg_dout <= src_rd[7:0];
                3'd3: cfg_dout <= src_rd[15:8];
                3'd4: cfg_dout <= len_rd[7:0];
                3'd5: cfg_dout <= len_rd[15:8];
                3'd6: cfg_dout <= value;
                3'd7: cfg_dout <= {6'b0, mode, busy};
                default: cfg_dout <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_dma.sv
// Scoreboard bench for vram_dma: expected VRAM writes are queued when an
// operation is launched and popped as the engine issues mem_we.
module tb_vram_dma;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [7:0]  cfg_din;
    logic [7:0]  cfg_dout;
    logic        busy;
    logic        done_irq;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic        mem_grant;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  ram [0:65535];
    logic        pre_we;
    logic [15:0] pre_addr;
    logic [7:0]  pre_data;
    logic        toggle;
    int          total;
    int          bad;
    int          wr_cnt;
    int          done_cnt;

    vram_dma #(.ADDR_W(16)) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_din   (cfg_din),
        .cfg_dout  (cfg_dout),
        .busy      (busy),
        .done_irq  (done_irq),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .mem_grant (mem_grant)
    );

    always #5 CLOCK = ~CLOCK;

    // Synchronous VRAM model with a bench-side preload port.
    always @(posedge CLOCK) begin
        if (pre_we) ram[pre_addr] <= pre_data;
        else if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    // Mid-cycle monitor: every write must be granted and match the queue head.
    always @(negedge CLOCK) begin
        if (done_irq === 1'b1) done_cnt++;
        if (mem_we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            total++;
            if (mem_grant !== 1'b1) begin
                bad++;
                $display("FAIL write_without_grant: addr=%h grant=%b required=1", mem_addr, mem_grant);
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr=%h data=%h, no write was expected", mem_addr, mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (mem_addr !== e.addr || mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL write_content: got %h<=%h required %h<=%h", mem_addr, mem_wdata, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
        if (toggle) mem_grant = ~mem_grant;
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_din  = d;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [7:0] d);
        cfg_we   = 1'b0;
        cfg_addr = a;
        tick();
        d = cfg_dout;
    endtask

    task automatic set16(input logic [2:0] base, input logic [15:0] v);
        cfg_write(base, v[7:0]);
        cfg_write(3'(base + 3'd1), v[15:8]);
    endtask

    task automatic read16(input logic [2:0] base, output logic [15:0] v);
        logic [7:0] lo;
        logic [7:0] hi;
        cfg_read(base, lo);
        cfg_read(3'(base + 3'd1), hi);
        v = {hi, lo};
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int max, output int n);
        n = 0;
        while (done_irq !== 1'b1 && n < max) begin
            tick();
            n++;
        end
        total++;
        if (done_irq !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout: done_irq=%b after %0d cycles, required 1", name, done_irq, n);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        RESET = 1'b1;
        tick();
        tick();
        total++;
        if ({busy, done_irq, mem_we, cfg_dout, mem_addr, mem_wdata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b dout=%h addr=%h wdata=%h required all 0",
                     busy, done_irq, mem_we, cfg_dout, mem_addr, mem_wdata);
        end
        RESET = 1'b0;
        for (int r = 0; r < 8; r++) begin
            cfg_read(3'(r), d);
            total++;
            if (d !== 8'h00) begin
                bad++;
                $display("FAIL reset_reg%0d: got %h required 00", r, d);
            end
        end
    endtask

    task automatic test_fill();
        int n;
        int w0;
        int d0;
        logic [15:0] v;
        mem_grant = 1'b1;
        set16(3'd0, 16'h0100);
        set16(3'd4, 16'd5);
        cfg_write(3'd6, 8'hAA);
        for (int i = 0; i < 5; i++) push_exp(16'(16'h0100 + i), 8'hAA);
        w0 = wr_cnt;
        d0 = done_cnt;
        cfg_write(3'd7, 8'h01);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL fill_busy_start: got %b required 1", busy);
        end
        wait_done("fill", 20, n);
        total++;
        if (n != 5 || busy !== 1'b0) begin
            bad++;
            $display("FAIL fill_latency: done after %0d cycles busy=%b, required 5 and 0", n, busy);
        end
        tick();
        total++;
        if (done_irq !== 1'b0 || wr_cnt - w0 != 5 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL fill_counts: done=%b writes=%0d pulses=%0d required 0/5/1", done_irq, wr_cnt - w0, done_cnt - d0);
        end
        read16(3'd0, v);
        total++;
        if (v !== 16'h0105) begin
            bad++;
            $display("FAIL fill_dst_readback: got %h required 0105", v);
        end
        read16(3'd4, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL fill_len_readback: got %h required 0000", v);
        end
    endtask

    task automatic test_copy();
        int n;
        logic [7:0] src_bytes [3];
        logic [7:0] d;
        src_bytes[0] = 8'h11;
        src_bytes[1] = 8'h22;
        src_bytes[2] = 8'h33;
        for (int i = 0; i < 3; i++) poke(16'(16'h0200 + i), src_bytes[i]);
        set16(3'd2, 16'h0200);
        set16(3'd0, 16'h0300);
        set16(3'd4, 16'd3);
        for (int i = 0; i < 3; i++) push_exp(16'(16'h0300 + i), src_bytes[i]);
        cfg_write(3'd7, 8'h03);
        wait_done("copy", 40, n);
        total++;
        if (n != 9 || busy !== 1'b0) begin
            bad++;
            $display("FAIL copy_latency: done after %0d cycles busy=%b, required 9 and 0", n, busy);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (ram[16'h0300 + i] !== src_bytes[i]) begin
                bad++;
                $display("FAIL copy_ram[%0d]: got %h required %h", i, ram[16'h0300 + i], src_bytes[i]);
            end
        end
        cfg_read(3'd7, d);
        total++;
        if (d !== 8'h02) begin
            bad++;
            $display("FAIL copy_ctrl_readback: got %h required 02", d);
        end
    endtask

    task automatic test_throttle();
        int n;
        int w0;
        set16(3'd0, 16'h0A00);
        set16(3'd4, 16'd4);
        cfg_write(3'd6, 8'h5A);
        for (int i = 0; i < 4; i++) push_exp(16'(16'h0A00 + i), 8'h5A);
        w0 = wr_cnt;
        mem_grant = 1'b0;
        toggle    = 1'b1;
        cfg_write(3'd7, 8'h01);
        wait_done("throttle_fill", 30, n);
        toggle    = 1'b0;
        mem_grant = 1'b1;
        total++;
        if (n != 7 || wr_cnt - w0 != 4) begin
            bad++;
            $display("FAIL throttle_fill: done at T+%0d writes=%0d, required T+8 and 4", n + 1, wr_cnt - w0);
        end
        tick();
        // Copy with the grant withdrawn while the captured byte waits in CP_WR.
        poke(16'h0400, 8'h5C);
        poke(16'h0500, 8'hEE);
        set16(3'd2, 16'h0400);
        set16(3'd0, 16'h0500);
        set16(3'd4, 16'd1);
        push_exp(16'h0500, 8'h5C);
        w0 = wr_cnt;
        cfg_write(3'd7, 8'h03);
        tick();
        tick();
        mem_grant = 1'b0;
        tick();
        tick();
        tick();
        total++;
        if (busy !== 1'b1 || wr_cnt != w0) begin
            bad++;
            $display("FAIL throttle_copy_stall: busy=%b writes=%0d required 1 and 0", busy, wr_cnt - w0);
        end
        mem_grant = 1'b1;
        wait_done("throttle_copy", 10, n);
        tick();
        total++;
        if (ram[16'h0500] !== 8'h5C) begin
            bad++;
            $display("FAIL throttle_copy_data: got %h required 5C", ram[16'h0500]);
        end
    endtask

    task automatic test_len_zero();
        int w0;
        int d0;
        logic [15:0] v;
        set16(3'd4, 16'd0);
        set16(3'd0, 16'h0B00);
        w0 = wr_cnt;
        d0 = done_cnt;
        cfg_write(3'd7, 8'h01);
        total++;
        if (done_irq !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL len0_done: done=%b busy=%b required 1 and 0", done_irq, busy);
        end
        // START during the FIN cycle is accepted.
        cfg_write(3'd7, 8'h01);
        total++;
        if (done_irq !== 1'b1) begin
            bad++;
            $display("FAIL fin_restart: done=%b required 1", done_irq);
        end
        tick();
        tick();
        total++;
        if (wr_cnt != w0 || done_cnt - d0 != 2) begin
            bad++;
            $display("FAIL len0_counts: writes=%0d pulses=%0d required 0 and 2", wr_cnt - w0, done_cnt - d0);
        end
        read16(3'd0, v);
        total++;
        if (v !== 16'h0B00) begin
            bad++;
            $display("FAIL len0_dst: got %h required 0B00", v);
        end
    endtask

    task automatic test_wrap();
        int n;
        logic [15:0] v;
        set16(3'd0, 16'hFFFE);
        set16(3'd4, 16'd3);
        cfg_write(3'd6, 8'h3C);
        push_exp(16'hFFFE, 8'h3C);
        push_exp(16'hFFFF, 8'h3C);
        push_exp(16'h0000, 8'h3C);
        cfg_write(3'd7, 8'h01);
        wait_done("wrap", 20, n);
        read16(3'd0, v);
        total++;
        if (v !== 16'h0001 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL wrap_dst: got %h pending=%0d required 0001 and 0", v, exp_q.size());
        end
    endtask

    task automatic test_abort();
        int w0;
        int d0;
        logic [15:0] v;
        set16(3'd0, 16'h0600);
        set16(3'd4, 16'd10);
        cfg_write(3'd6, 8'h77);
        push_exp(16'h0600, 8'h77);
        push_exp(16'h0601, 8'h77);
        w0 = wr_cnt;
        d0 = done_cnt;
        cfg_write(3'd7, 8'h01);
        tick();
        tick();
        mem_grant = 1'b0;
        cfg_write(3'd7, 8'h04);
        total++;
        if (done_irq !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort_fin: done=%b busy=%b required 1 and 0", done_irq, busy);
        end
        mem_grant = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (wr_cnt - w0 != 2 || done_cnt - d0 != 1) begin
            bad++;
            $display("FAIL abort_counts: writes=%0d pulses=%0d required 2 and 1", wr_cnt - w0, done_cnt - d0);
        end
        read16(3'd4, v);
        total++;
        if (v !== 16'h0008) begin
            bad++;
            $display("FAIL abort_len: got %h required 0008", v);
        end
    endtask

    task automatic test_lockout();
        int n;
        int w0;
        logic [7:0] d;
        logic [15:0] v;
        set16(3'd0, 16'h0700);
        set16(3'd4, 16'd6);
        cfg_write(3'd6, 8'h99);
        for (int i = 0; i < 6; i++) push_exp(16'(16'h0700 + i), 8'h99);
        w0 = wr_cnt;
        cfg_write(3'd7, 8'h01);
        cfg_write(3'd0, 8'h55);
        cfg_read(3'd0, d);
        total++;
        if (d !== 8'h01) begin
            bad++;
            $display("FAIL lockout_dst_live: got %h required 01", d);
        end
        cfg_write(3'd7, 8'h01);
        cfg_write(3'd6, 8'h11);
        wait_done("lockout", 20, n);
        tick();
        total++;
        if (n != 2 || wr_cnt - w0 != 6) begin
            bad++;
            $display("FAIL lockout_restart: done after %0d more cycles writes=%0d required 2 and 6", n, wr_cnt - w0);
        end
        read16(3'd0, v);
        total++;
        if (v !== 16'h0706) begin
            bad++;
            $display("FAIL lockout_dst_final: got %h required 0706", v);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        int d0;
        logic [7:0] d;
        set16(3'd2, 16'h0200);
        set16(3'd0, 16'h0800);
        set16(3'd4, 16'd3);
        w0 = wr_cnt;
        d0 = done_cnt;
        cfg_write(3'd7, 8'h03);
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        total++;
        if (busy !== 1'b0 || done_irq !== 1'b0 || mem_we !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_outputs: busy=%b done=%b we=%b required 0", busy, done_irq, mem_we);
        end
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (wr_cnt != w0 || done_cnt != d0) begin
            bad++;
            $display("FAIL reset_mid_activity: writes=%0d pulses=%0d required 0 and 0", wr_cnt - w0, done_cnt - d0);
        end
        for (int r = 0; r < 8; r++) begin
            cfg_read(3'(r), d);
            total++;
            if (d !== 8'h00) begin
                bad++;
                $display("FAIL reset_mid_reg%0d: got %h required 00", r, d);
            end
        end
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        wr_cnt    = 0;
        done_cnt  = 0;
        toggle    = 1'b0;
        RESET     = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_din   = '0;
        mem_grant = 1'b1;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        test_reset();
        test_fill();
        test_copy();
        test_throttle();
        test_len_zero();
        test_wrap();
        test_abort();
        test_lockout();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d writes still pending, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_dma.md
Name: vram_dma

Overview:
- CPU-programmable block engine in front of the 64 KB video RAM that the scan-out adapter reads for its 1bpp display.
- Fills a byte range with a constant (screen clear) or copies a byte range forward (scrolling), so the AVR core does not spend cycles per byte.
- Uses the VRAM port only in cycles where the video fetch does not need it (mem_grant=1).

Parameters:
- ADDR_W, 16, VRAM address width; address and length counters are this wide.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- cfg_we  in  1  register write strobe, one byte per cycle
- cfg_addr  in  3  register select
- cfg_din  in  8  register write data
- cfg_dout  out  8  register read data, registered (valid the cycle after cfg_addr)
- busy  out  1  operation in progress
- done_irq  out  1  one-cycle pulse when an operation ends
- mem_addr  out  ADDR_W  VRAM address
- mem_wdata  out  8  VRAM write data
- mem_we  out  1  VRAM write enable
- mem_rdata  in  8  VRAM read data; synchronous RAM, valid the cycle after mem_addr
- mem_grant  in  1  1 = engine may use the VRAM port this cycle

Behaviour:
- Registers:
  - 0/1 DST lo/hi; 2/3 SRC lo/hi; 4/5 LEN lo/hi; 6 VALUE.
  - 7 CTRL write: bit0 START, bit1 MODE (0 fill, 1 copy), bit2 ABORT.
  - 7 read: {6'b0, MODE, busy}.
  - Registers 0-5 read back live counter values.
- While busy:
  - writes to registers 0-6 are ignored;
  - START is ignored;
  - ABORT is honoured.
- Reset values:
  - all registers 0; state IDLE;
  - busy, done_irq, mem_we, cfg_dout = 0; mem_addr, mem_wdata = 0.
- States:
  - IDLE
  - FILL
  - CP_RD (read src)
  - CP_CAP (capture mem_rdata into hold register; port unused)
  - CP_WR (write hold to dst)
  - FIN
- START written in cycle T:
  - LEN != 0: state becomes FILL or CP_RD at T+1; busy=1 from T+1.
  - LEN == 0: state becomes FIN at T+1; no memory access.
- FILL:
  - mem_addr = DST, mem_wdata = VALUE, mem_we = mem_grant (combinational).
  - On a granted cycle: DST += 1, LEN -= 1.
  - If the new LEN == 0, go to FIN.
  - Ungranted cycle: hold all state.
- CP_RD:
  - mem_addr = SRC, mem_we = 0.
  - Granted: SRC += 1, go to CP_CAP.
  - Ungranted: stay in CP_RD.
- CP_CAP:
  - hold <= mem_rdata, unconditionally; go to CP_WR.
- CP_WR:
  - mem_addr = DST, mem_wdata = hold, mem_we = mem_grant.
  - Granted: DST += 1, LEN -= 1, then go to FIN if the new LEN == 0, else CP_RD.
  - Ungranted: stay in CP_WR; hold is unchanged.
- FIN:
  - busy = 0 and done_irq = 1 for exactly this one cycle; next state IDLE.
  - A START written during the FIN cycle is accepted, since busy = 0 there.
- Throughput with grant held at 1: fill 1 byte/cycle; copy 3 cycles/byte.
- Addresses wrap modulo 2^ADDR_W (0xFFFF+1 -> 0x0000), and operation continues across the wrap.
- Copy is forward only:
  - overlapping ranges with DST > SRC replicate data;
  - this is intended behaviour and is not an error.
- ABORT written in any non-IDLE state:
  - next state FIN; no mem_we from the following cycle onward;
  - counters keep their current values.
  - START and ABORT written in the same cycle: ABORT wins when busy, START wins when idle.
- RESET asserted mid-operation: immediate return to reset values; no done_irq pulse.
- mem_we is never asserted outside FILL or CP_WR, and never while mem_grant = 0.

Test Plan:
- Fill: DST=0x0100, LEN=5, VALUE=0xAA, START (mode 0), grant=1 -> mem_we high 5 consecutive cycles at 0x0100..0x0104 with data 0xAA; then done_irq for 1 cycle; DST reads 0x0105, LEN reads 0.
- Copy: RAM[0x0200..0x0202]=11,22,33; SRC=0x0200, DST=0x0300, LEN=3, mode 1 -> 0x0300..0x0302 = 11,22,33 after 9 cycles; busy falls with done_irq.
- Grant throttling: fill LEN=4 with grant toggling 1,0,1,0... -> exactly 4 writes, none in grant=0 cycles, completion after 8 cycles; copy with grant dropped during CP_WR -> written byte still equals the source.
- Boundaries:
  - LEN=0 START -> done_irq at T+1, zero mem_we.
  - DST=0xFFFE, LEN=3 fill -> writes at 0xFFFE, 0xFFFF, 0x0000.
- Abort and reset:
  - ABORT after 2 bytes of a LEN=10 fill -> no further writes, done_irq once, LEN reads 8.
  - RESET mid-copy -> busy=0, no done_irq, all registers read 0.
- Register lockout: write DST while busy -> ignored (readback shows the counter value); START while busy -> no restart.
